proc_elem_mac: RTL and testbench

PROC_ELEM_MAC -- requirements
Module: proc_elem_mac

---
 rtl/proc_elem_mac.sv | 234 +++++++++++++++++++++++
 tb/tb_proc_elem_mac.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/proc_elem_mac.sv
// -----------------------------------------------------------------------------
// proc_elem_mac
//
// One processing element of a systolic MAC array. Activations travel left to
// right, partial sums (and, during weight load, the weights themselves)
// travel top to bottom. Each PE holds a small bank of signed weights and can
// run in one of three modes:
//   PASS (00, 11) : forward in_top to out_down unchanged.
//   WS   (01)     : weight-stationary MAC, out_down = sat(in_top + in_left*w).
//   ACC  (10)     : output-stationary, local acc += in_left*w, emitted on drain.
//
// Valid semantics (applies to every *_valid in this block): a qualifier that
// is high means its paired data bus carries meaningful data in that same
// cycle. There is no backpressure; a consumer must take the data when it is
// offered.
//
// Ports
//   clk               rising-edge clock
//   reset             asynchronous active-high reset
//   in_top            partial sum from above; weight data on [DATA_WIDTH-1:0]
//   in_top_valid      in_top qualifier
//   in_left           activation from the left
//   in_left_valid     in_left qualifier
//   weight_WE         weight-load enable (overrides mode)
//   weight_sel        bank entry used for compute (combinational read)
//   mode              operating mode, see above
//   acc_drain         ACC mode: emit accumulator on out_down and restart it
//   acc_clear         clear accumulator (ACC mode only) and sat_flag (always)
//   out_down          registered result to the PE below
//   out_down_valid    out_down qualifier
//   out_right         in_left delayed one cycle
//   out_right_valid   in_left_valid delayed one cycle
//   sat_flag          sticky saturation indicator
//   weight_load_done  one-cycle pulse after the last bank entry is written
// -----------------------------------------------------------------------------
module proc_elem_mac #(
    parameter int DATA_WIDTH   = 16,
    parameter int ACC_WIDTH    = 32,
    parameter int NUM_WEIGHTS  = 4,
    parameter int W_ADDR_WIDTH = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [ACC_WIDTH-1:0]    in_top,
    input  logic                    in_top_valid,
    input  logic [DATA_WIDTH-1:0]   in_left,
    input  logic                    in_left_valid,
    input  logic                    weight_WE,
    input  logic [W_ADDR_WIDTH-1:0] weight_sel,
    input  logic [1:0]              mode,
    input  logic                    acc_drain,
    input  logic                    acc_clear,
    output logic [ACC_WIDTH-1:0]    out_down,
    output logic                    out_down_valid,
    output logic [DATA_WIDTH-1:0]   out_right,
    output logic                    out_right_valid,
    output logic                    sat_flag,
    output logic                    weight_load_done
);

    // -------------------------------------------------------------------------
    // Constants
    // -------------------------------------------------------------------------
    localparam logic [1:0] MODE_WS  = 2'b01;
    localparam logic [1:0] MODE_ACC = 2'b10;

    // The bank is sized to the full address space so that any weight_sel value
    // reads a defined entry; entries at or above NUM_WEIGHTS are never
    // written and therefore always read as zero.
    localparam int BANK_DEPTH = 1 << W_ADDR_WIDTH;

    localparam logic [W_ADDR_WIDTH-1:0] LAST_ENTRY = W_ADDR_WIDTH'(NUM_WEIGHTS - 1);

    localparam logic signed [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};

    // -------------------------------------------------------------------------
    // Saturating signed add. Bit ACC_WIDTH of the return value is the
    // overflow indicator, the lower bits are the clamped sum.
    // -------------------------------------------------------------------------
    function automatic logic [ACC_WIDTH:0] sat_add(
        input logic signed [ACC_WIDTH-1:0] a,
        input logic signed [ACC_WIDTH-1:0] b
    );
        logic signed [ACC_WIDTH:0] full;
        full = (ACC_WIDTH+1)'(a) + (ACC_WIDTH+1)'(b);
        // Overflow iff the extra sign bit disagrees with the result sign bit.
        if (full[ACC_WIDTH] != full[ACC_WIDTH-1]) begin
            sat_add = {1'b1, (full[ACC_WIDTH] ? ACC_MIN : ACC_MAX)};
        end else begin
            sat_add = {1'b0, full[ACC_WIDTH-1:0]};
        end
    endfunction

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    logic signed [DATA_WIDTH-1:0] bank [BANK_DEPTH];
    logic [W_ADDR_WIDTH-1:0]      wr_ptr;
    logic signed [ACC_WIDTH-1:0]  acc;

    // -------------------------------------------------------------------------
    // Combinational datapath
    // -------------------------------------------------------------------------
    logic                          load;
    logic                          is_ws;
    logic                          is_acc;
    logic                          ws_fire;
    logic signed [DATA_WIDTH-1:0]  act;
    logic signed [DATA_WIDTH-1:0]  w_cur;
    logic signed [2*DATA_WIDTH-1:0] product;
    logic signed [ACC_WIDTH-1:0]   prod_ext;
    logic signed [ACC_WIDTH-1:0]   top_s;
    logic [ACC_WIDTH:0]            ws_res;
    logic [ACC_WIDTH:0]            acc_res;
    logic                          acc_step;
    logic                          sat_event;

    assign load    = weight_WE & in_top_valid;
    assign is_ws   = (mode == MODE_WS);
    assign is_acc  = (mode == MODE_ACC);
    assign ws_fire = in_top_valid & in_left_valid;

    // Weight read is combinational so weight_sel takes effect at the next edge.
    assign act      = in_left;
    assign w_cur    = bank[weight_sel];
    assign product  = act * w_cur;
    assign prod_ext = ACC_WIDTH'(product);
    assign top_s    = in_top;

    assign ws_res  = sat_add(top_s, prod_ext);
    assign acc_res = sat_add(acc, prod_ext);

    // A plain accumulate step happens only when neither clear nor drain
    // redirects the accumulator this cycle.
    assign acc_step = is_acc & in_left_valid & ~acc_clear & ~acc_drain;

    // Saturation only counts for an add whose result is actually registered.
    assign sat_event = ~weight_WE &
                       ((is_ws & ws_fire & ws_res[ACC_WIDTH]) |
                        (acc_step & acc_res[ACC_WIDTH]));

    // -------------------------------------------------------------------------
    // Weight bank and write pointer. A reset mid-load discards the partial
    // load: the pointer restarts at entry 0 and the bank is zeroed.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < BANK_DEPTH; i++) begin
                bank[i] <= '0;
            end
            wr_ptr           <= '0;
            weight_load_done <= 1'b0;
        end else begin
            weight_load_done <= load && (wr_ptr == LAST_ENTRY);
            if (load) begin
                bank[wr_ptr] <= in_top[DATA_WIDTH-1:0];
                if (wr_ptr == LAST_ENTRY) begin
                    wr_ptr <= '0;
                end else begin
                    wr_ptr <= wr_ptr + 1'b1;
                end
            end
        end
    end

    // -------------------------------------------------------------------------
    // Horizontal activation pipeline: a pure one-cycle delay in every mode.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_right       <= '0;
            out_right_valid <= 1'b0;
        end else begin
            out_right       <= in_left;
            out_right_valid <= in_left_valid;
        end
    end

    // -------------------------------------------------------------------------
    // Sticky saturation flag. acc_clear wins over a same-cycle saturation and
    // clears the flag regardless of mode.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sat_flag <= 1'b0;
        end else if (acc_clear) begin
            sat_flag <= 1'b0;
        end else if (sat_event) begin
            sat_flag <= 1'b1;
        end
    end

    // -------------------------------------------------------------------------
    // Vertical result path and local accumulator.
    // Weight load has top priority and ripples in_top down the column while
    // holding acc. The accumulator is only touched in ACC mode, so switching
    // modes never disturbs it.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_down       <= '0;
            out_down_valid <= 1'b0;
            acc            <= '0;
        end else if (weight_WE) begin
            out_down       <= in_top;
            out_down_valid <= in_top_valid;
        end else if (is_ws) begin
            // out_down keeps its last result while no new sum is produced.
            out_down_valid <= ws_fire;
            if (ws_fire) begin
                out_down <= ws_res[ACC_WIDTH-1:0];
            end
        end else if (is_acc) begin
            out_down_valid <= acc_drain;
            // The drain always emits the pre-clear, pre-update value.
            if (acc_drain) begin
                out_down <= acc;
            end
            if (acc_clear) begin
                acc <= '0;
            end else if (acc_drain) begin
                // Restart the accumulation with this cycle's product, if any.
                acc <= in_left_valid ? prod_ext : '0;
            end else if (in_left_valid) begin
                acc <= acc_res[ACC_WIDTH-1:0];
            end
        end else begin
            out_down       <= in_top;
            out_down_valid <= in_top_valid;
        end
    end

endmodule

// File: tb/tb_proc_elem_mac.sv
// -----------------------------------------------------------------------------
// tb_proc_elem_mac
//
// Directed bench for proc_elem_mac with default parameters (16-bit data,
// 32-bit accumulator, 4 weights). Inputs change 1 time unit after a rising
// edge, outputs are sampled 1 time unit after the following rising edge.
// Expected out_down values from the weight-load phase go through exp_q;
// all other expectations are hand-computed constants in the step list.
// -----------------------------------------------------------------------------
module tb_proc_elem_mac;

    localparam int DW = 16;
    localparam int AW = 32;
    localparam int NW = 4;
    localparam int WA = 2;

    // -------------------------------------------------------------------------
    // Clock / reset
    // -------------------------------------------------------------------------
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    // -------------------------------------------------------------------------
    // DUT
    // -------------------------------------------------------------------------
    logic [AW-1:0] in_top;
    logic          in_top_valid;
    logic [DW-1:0] in_left;
    logic          in_left_valid;
    logic          weight_WE;
    logic [WA-1:0] weight_sel;
    logic [1:0]    mode;
    logic          acc_drain;
    logic          acc_clear;
    logic [AW-1:0] out_down;
    logic          out_down_valid;
    logic [DW-1:0] out_right;
    logic          out_right_valid;
    logic          sat_flag;
    logic          weight_load_done;

    proc_elem_mac #(
        .DATA_WIDTH  (DW),
        .ACC_WIDTH   (AW),
        .NUM_WEIGHTS (NW),
        .W_ADDR_WIDTH(WA)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .in_top          (in_top),
        .in_top_valid    (in_top_valid),
        .in_left         (in_left),
        .in_left_valid   (in_left_valid),
        .weight_WE       (weight_WE),
        .weight_sel      (weight_sel),
        .mode            (mode),
        .acc_drain       (acc_drain),
        .acc_clear       (acc_clear),
        .out_down        (out_down),
        .out_down_valid  (out_down_valid),
        .out_right       (out_right),
        .out_right_valid (out_right_valid),
        .sat_flag        (sat_flag),
        .weight_load_done(weight_load_done)
    );

    // -------------------------------------------------------------------------
    // Scoreboard
    // -------------------------------------------------------------------------
    int            total = 0;
    int            bad   = 0;
    logic [AW-1:0] exp_q[$];

    task automatic chk(input string tag, input logic [AW-1:0] obs, input logic [AW-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got=%0h want=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_down(input string tag);
        if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL %s: got=%0h want=<empty scoreboard>", tag, out_down);
        end else begin
            chk(tag, out_down, exp_q.pop_front());
        end
    endtask

    task automatic check_outputs_zero(input string tag);
        chk({tag, "_down"},  out_down, 0);
        chk({tag, "_dv"},    32'(out_down_valid), 0);
        chk({tag, "_right"}, 32'(out_right), 0);
        chk({tag, "_rv"},    32'(out_right_valid), 0);
        chk({tag, "_sat"},   32'(sat_flag), 0);
        chk({tag, "_wld"},   32'(weight_load_done), 0);
    endtask

    // -------------------------------------------------------------------------
    // Driver tasks
    // -------------------------------------------------------------------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        in_top        = '0;
        in_top_valid  = 1'b0;
        in_left       = '0;
        in_left_valid = 1'b0;
        weight_WE     = 1'b0;
        acc_drain     = 1'b0;
        acc_clear     = 1'b0;
    endtask

    // One weight write; the word must appear on out_down one cycle later.
    task automatic load_word(input logic [AW-1:0] v, input logic exp_done);
        weight_WE    = 1'b1;
        in_top       = v;
        in_top_valid = 1'b1;
        exp_q.push_back(v);
        tick();
        check_down("load_echo");
        chk("load_echo_valid", 32'(out_down_valid), 1);
        chk("load_done", 32'(weight_load_done), 32'(exp_done));
    endtask

    task automatic ws_op(input logic [WA-1:0] sel, input logic [DW-1:0] left,
                         input logic [AW-1:0] top, input logic [AW-1:0] exp_down,
                         input string tag);
        idle();
        mode          = 2'b01;
        weight_sel    = sel;
        in_left       = left;
        in_left_valid = 1'b1;
        in_top        = top;
        in_top_valid  = 1'b1;
        tick();
        chk(tag, out_down, exp_down);
        chk({tag, "_valid"}, 32'(out_down_valid), 1);
    endtask

    task automatic acc_in(input logic [DW-1:0] left);
        idle();
        mode          = 2'b10;
        in_left       = left;
        in_left_valid = 1'b1;
        tick();
        chk("acc_no_valid", 32'(out_down_valid), 0);
    endtask

    task automatic drain(input logic lv, input logic [DW-1:0] left, input logic clr,
                         input logic [AW-1:0] exp_down, input string tag);
        idle();
        mode          = 2'b10;
        acc_drain     = 1'b1;
        acc_clear     = clr;
        in_left       = left;
        in_left_valid = lv;
        tick();
        chk(tag, out_down, exp_down);
        chk({tag, "_valid"}, 32'(out_down_valid), 1);
    endtask

    // -------------------------------------------------------------------------
    // Directed sequence
    // -------------------------------------------------------------------------
    initial begin
        reset      = 1'b1;
        mode       = 2'b00;
        weight_sel = '0;
        idle();
        repeat (2) @(posedge clk);
        #1;
        check_outputs_zero("reset");
        reset = 1'b0;

        // ---- weight load 3,-2,7,1 with activations flowing right ----
        in_left       = 16'h0009;
        in_left_valid = 1'b1;
        load_word(32'd3, 1'b0);
        chk("load_right", 32'(out_right), 32'h9);
        chk("load_right_valid", 32'(out_right_valid), 1);
        in_left_valid = 1'b0;
        load_word(32'hFFFF_FFFE, 1'b0);
        chk("load_right_valid_low", 32'(out_right_valid), 0);
        load_word(32'd7, 1'b0);
        load_word(32'd1, 1'b1);
        idle();
        tick();
        chk("load_done_single", 32'(weight_load_done), 0);

        // ---- WS: bank readback and arithmetic ----
        ws_op(2'd0, 16'd5, 32'd10, 32'd25, "ws_w0");
        chk("ws_right", 32'(out_right), 32'd5);
        chk("ws_right_valid", 32'(out_right_valid), 1);
        ws_op(2'd1, 16'd3, 32'd100, 32'd94, "ws_w1");
        ws_op(2'd2, 16'hFFFF, 32'd0, 32'hFFFF_FFF9, "ws_w2");
        ws_op(2'd3, 16'd1000, 32'hFFFF_FFFF, 32'd999, "ws_w3");
        // Partial sum not valid: output holds, valid drops.
        in_top_valid = 1'b0;
        in_left      = 16'd2;
        tick();
        chk("ws_hold", out_down, 32'd999);
        chk("ws_hold_valid", 32'(out_down_valid), 0);
        chk("ws_no_sat", 32'(sat_flag), 0);

        // ---- reload bank with 32767,-2,7,1 ----
        load_word(32'h0000_7FFF, 1'b0);
        load_word(32'hFFFF_FFFE, 1'b0);
        load_word(32'd7, 1'b0);
        load_word(32'd1, 1'b1);

        // ---- saturation ----
        ws_op(2'd0, 16'h7FFF, 32'h7FFF_FFF0, 32'h7FFF_FFFF, "ws_sat_pos");
        chk("sat_pos_flag", 32'(sat_flag), 1);
        idle();
        mode      = 2'b00;
        acc_clear = 1'b1;
        tick();
        chk("sat_clear_pass", 32'(sat_flag), 0);
        ws_op(2'd0, 16'h8001, 32'h8000_0010, 32'h8000_0000, "ws_sat_neg");
        chk("sat_neg_flag", 32'(sat_flag), 1);
        idle();
        mode = 2'b00;
        repeat (10) tick();
        chk("sat_sticky", 32'(sat_flag), 1);
        acc_clear = 1'b1;
        tick();
        chk("sat_clear_any_mode", 32'(sat_flag), 0);

        // ---- ACC with w=-2 ----
        weight_sel = 2'd1;
        acc_in(16'd1);
        acc_in(16'd2);
        acc_in(16'd3);
        drain(1'b0, 16'd0, 1'b0, 32'hFFFF_FFF4, "acc_drain_m12");
        idle();
        tick();
        chk("acc_drain_one_cycle", 32'(out_down_valid), 0);
        chk("acc_drain_hold", out_down, 32'hFFFF_FFF4);
        drain(1'b0, 16'd0, 1'b0, 32'd0, "acc_drain_empty");

        // Drain together with a valid activation restarts acc at the product.
        acc_in(16'd1);
        acc_in(16'd2);
        acc_in(16'd3);
        drain(1'b1, 16'd4, 1'b0, 32'hFFFF_FFF4, "acc_drain_with_in");
        drain(1'b0, 16'd0, 1'b0, 32'hFFFF_FFF8, "acc_drain_restart");

        // Clear with drain: pre-clear value out, clear beats the product.
        acc_in(16'd5);
        drain(1'b1, 16'd3, 1'b1, 32'hFFFF_FFF6, "acc_drain_clear");
        drain(1'b0, 16'd0, 1'b0, 32'd0, "acc_after_clear");

        // Mode changes and out-of-mode drain/clear leave acc alone.
        acc_in(16'd1);
        idle();
        mode         = 2'b00;
        acc_drain    = 1'b1;
        in_top       = 32'h55;
        in_top_valid = 1'b1;
        tick();
        chk("pass_ignores_drain", out_down, 32'h55);
        chk("pass_valid", 32'(out_down_valid), 1);
        drain(1'b0, 16'd0, 1'b0, 32'hFFFF_FFFE, "acc_kept_over_pass");
        acc_in(16'd2);
        idle();
        mode      = 2'b01;
        acc_clear = 1'b1;
        tick();
        drain(1'b0, 16'd0, 1'b0, 32'hFFFF_FFFC, "acc_kept_over_ws_clear");

        // ---- reset in the middle of a load ----
        idle();
        tick();
        load_word(32'd11, 1'b0);
        load_word(32'd12, 1'b0);
        in_left       = 16'h1234;
        in_left_valid = 1'b1;
        reset         = 1'b1;
        #1;
        check_outputs_zero("async_reset");
        tick();
        tick();
        reset = 1'b0;
        ws_op(2'd0, 16'd1, 32'd0, 32'd0, "bank0_zero");
        ws_op(2'd1, 16'd1, 32'd0, 32'd0, "bank1_zero");
        ws_op(2'd2, 16'd1, 32'd0, 32'd0, "bank2_zero");
        ws_op(2'd3, 16'd1, 32'd0, 32'd0, "bank3_zero");
        load_word(32'd20, 1'b0);
        load_word(32'd21, 1'b0);
        load_word(32'd22, 1'b0);
        load_word(32'd23, 1'b1);
        ws_op(2'd0, 16'd1, 32'd0, 32'd20, "reload_entry0");
        ws_op(2'd3, 16'd1, 32'd0, 32'd23, "reload_entry3");

        chk("scoreboard_drained", 32'(exp_q.size()), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
